asym_fifo_write_wider: RTL

- Single-clock FIFO with a wide write port and a narrow read port.
- Accepts DATAWIDTHW-bit words on a valid/ready slave interface and streams them out as DATAWIDTHR-bit lanes on a valid/ready master interface, lane 0 (bits [DATAWIDTHR-1:0]) first.
- Used to serialise wide memory/DSP words into the narrow processor-side path.

---
 rtl/asym_fifo_write_wider.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/asym_fifo_write_wider.sv
// asym_fifo_write_wider: single-clock FIFO, wide write port, narrow read port.
// Each DATAWIDTHW-bit word is stored whole. It is streamed out as RATIO lanes
// of DATAWIDTHR bits, lane 0 (least significant) first.
// m_data is the synchronous RAM read register. An entry is freed on the edge
// that copies its last lane into m_data.
// Optional macro ASYM_FIFO_LEVEL_EN adds two registered level ports:
// wr_free (free entries) and rd_level (lanes still waiting in RAM).
module asym_fifo_write_wider #(
    parameter int DATAWIDTHW = 512,
    parameter int DATAWIDTHR = 32,
    parameter int DEPTHW     = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATAWIDTHW-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATAWIDTHR-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef ASYM_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTHW):0]                          wr_free,
    output logic [$clog2(DEPTHW*(DATAWIDTHW/DATAWIDTHR)):0] rd_level
`endif
);

    localparam int RATIO = DATAWIDTHW / DATAWIDTHR;
    localparam int AW    = $clog2(DEPTHW);
    localparam int LW    = $clog2(RATIO);
    localparam int PW    = AW + LW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTHW);

    logic [DATAWIDTHW-1:0] mem_q [DEPTHW];

    logic [AW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [AW:0]           used_q, used_d;
    logic                  s_ready_q, s_ready_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATAWIDTHR-1:0] m_data_q, m_data_d;

    logic                  accept_s;
    logic                  out_free_s;
    logic                  avail_s;
    logic                  load_s;
    logic                  release_s;
    logic [PW:0]           lanes_s;
    logic [DATAWIDTHW-1:0] rd_word_s;
    logic [DATAWIDTHR-1:0] rd_lane_s;

    // Handshake qualifiers and lane availability.
    // Occupied entries times RATIO, minus the lanes already taken from the
    // partially read head entry.
    always_comb begin
        accept_s   = s_valid & s_ready_q;
        out_free_s = ~m_valid_q | m_ready;
        lanes_s    = {used_q, {LW{1'b0}}} - {{(AW+1){1'b0}}, rptr_q[LW-1:0]};
        avail_s    = (lanes_s != (PW+1)'(0));
        load_s     = out_free_s & avail_s;
        release_s  = load_s & (rptr_q[LW-1:0] == {LW{1'b1}});
        rd_word_s  = mem_q[rptr_q[PW-1:LW]];
        rd_lane_s  = rd_word_s[int'(rptr_q[LW-1:0])*DATAWIDTHR +: DATAWIDTHR];
    end

    // Next-state for the pointers, the occupancy count and the write-ready flag.
    always_comb begin
        wptr_d = wptr_q;
        used_d = used_q;
        if (accept_s) begin
            wptr_d = wptr_q + AW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (accept_s && !release_s) begin
            used_d = used_q + (AW+1)'(1);
        end else if (!accept_s && release_s) begin
            used_d = used_q - (AW+1)'(1);
        end else begin
            used_d = used_q;
        end
        // Space freed by a release only becomes visible one cycle later.
        s_ready_d = (used_d < DEPTH_C);
    end

    // Next-state for the output register and the read pointer.
    always_comb begin
        rptr_d    = rptr_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (load_s) begin
            rptr_d    = rptr_q + PW'(1);
            m_valid_d = 1'b1;
            m_data_d  = rd_lane_s;
        end else if (out_free_s) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Wide storage write. Pointer reset alone invalidates stale contents.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_q[wptr_q] <= s_data;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q    <= AW'(0);
            rptr_q    <= PW'(0);
            used_q    <= (AW+1)'(0);
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= DATAWIDTHR'(0);
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            used_q    <= used_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

`ifdef ASYM_FIFO_LEVEL_EN
    logic [AW:0] wr_free_q;
    logic [PW:0] rd_level_q;

    // Level registers track the next-state counts, so they agree with the pointers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_free_q  <= DEPTH_C;
            rd_level_q <= (PW+1)'(0);
        end else begin
            wr_free_q  <= DEPTH_C - used_d;
            rd_level_q <= {used_d, {LW{1'b0}}} - {{(AW+1){1'b0}}, rptr_d[LW-1:0]};
        end
    end

    assign wr_free  = wr_free_q;
    assign rd_level = rd_level_q;
`endif

endmodule
